// File: rtl/rx_block_ap_regs.sv
// AXI4-Lite register block: C_NUM_RW control registers with per-register write pulses,
// followed by C_NUM_RO read-only status words. Independent read and write paths.
module rx_block_ap_regs #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 8,
    parameter int unsigned C_NUM_RW           = 4,
    parameter int unsigned C_NUM_RO           = 4
) (
    input  logic                                   s_axi_aclk,
    input  logic                                   s_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic [2:0]                             s_axi_awprot,
    input  logic                                   s_axi_awvalid,
    output logic                                   s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        s_axi_wstrb,
    input  logic                                   s_axi_wvalid,
    output logic                                   s_axi_wready,
    output logic [1:0]                             s_axi_bresp,
    output logic                                   s_axi_bvalid,
    input  logic                                   s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic [2:0]                             s_axi_arprot,
    input  logic                                   s_axi_arvalid,
    output logic                                   s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                             s_axi_rresp,
    output logic                                   s_axi_rvalid,
    input  logic                                   s_axi_rready,
    output logic [C_NUM_RW*C_S_AXI_DATA_WIDTH-1:0] ctrl_o,
    output logic [C_NUM_RW-1:0]                    wr_pulse_o,
    input  logic [((C_NUM_RO > 0) ? C_NUM_RO : 1)*C_S_AXI_DATA_WIDTH-1:0] status_i
);

    localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
    localparam int unsigned NB       = DW / 8;
    localparam int unsigned ADDR_LSB = $clog2(NB);
    localparam int unsigned IW       = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
    localparam int unsigned NUM_MAP  = C_NUM_RW + C_NUM_RO;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    wstate_e       wstate_q, wstate_d;
    rstate_e       rstate_q, rstate_d;
    logic          active_q;
    logic [IW-1:0] awidx_q;
    logic [DW-1:0] wdata_q;
    logic [NB-1:0] wstrb_q;
    logic [DW-1:0] ctrl_q [C_NUM_RW];
    logic [C_NUM_RW-1:0] pulse_q;
    logic [1:0]    bresp_q, rresp_q;
    logic [DW-1:0] rdata_q;

    logic          aw_hs, w_hs, ar_hs, wr_commit;
    logic [31:0]   wr_idx, rd_idx;
    logic [DW-1:0] wr_data, rd_word;
    logic [NB-1:0] wr_strb;
    logic [1:0]    wr_resp, rd_resp;

    // Protection bits and sub-word address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s_axi_awprot, s_axi_arprot,
                           s_axi_awaddr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0]};

    // Ready outputs stay low during reset and rise on the first edge after release.
    assign s_axi_awready = active_q & ((wstate_q == W_IDLE) | (wstate_q == W_HAVE_D));
    assign s_axi_wready  = active_q & ((wstate_q == W_IDLE) | (wstate_q == W_HAVE_A));
    assign s_axi_bvalid  = (wstate_q == W_RESP);
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = active_q & (rstate_q == R_IDLE);
    assign s_axi_rvalid  = (rstate_q == R_DATA);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign wr_pulse_o    = pulse_q;

    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid & s_axi_wready;
    assign ar_hs = s_axi_arvalid & s_axi_arready;

    // The completing beat may arrive on this very edge, so bypass the holding registers.
    assign wr_idx  = 32'(aw_hs ? s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB] : awidx_q);
    assign wr_data = w_hs ? s_axi_wdata : wdata_q;
    assign wr_strb = w_hs ? s_axi_wstrb : wstrb_q;
    assign rd_idx  = 32'(s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB]);

    for (genvar k = 0; k < C_NUM_RW; k++) begin : g_ctrl
        assign ctrl_o[k*DW +: DW] = ctrl_q[k];
    end

    // Ready gate: low while in reset, high from the first edge afterwards.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) active_q <= 1'b0;
        else                active_q <= 1'b1;
    end

    // Write response decode for the target index.
    always_comb begin
        wr_resp = RESP_DECERR;
        if (wr_idx < C_NUM_RW)     wr_resp = RESP_OKAY;
        else if (wr_idx < NUM_MAP) wr_resp = RESP_SLVERR;
    end

    // Write FSM next state; commit when the address/data pair completes.
    always_comb begin
        wstate_d  = wstate_q;
        wr_commit = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wstate_d  = W_RESP;
                    wr_commit = 1'b1;
                end else if (aw_hs) begin
                    wstate_d = W_HAVE_A;
                end else if (w_hs) begin
                    wstate_d = W_HAVE_D;
                end
            end
            W_HAVE_A: if (w_hs) begin
                wstate_d  = W_RESP;
                wr_commit = 1'b1;
            end
            W_HAVE_D: if (aw_hs) begin
                wstate_d  = W_RESP;
                wr_commit = 1'b1;
            end
            W_RESP:   if (s_axi_bready) wstate_d = W_IDLE;
            default:  wstate_d = W_IDLE;
        endcase
    end

    // Write FSM state and holding registers for a beat that arrives early.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wstate_q <= W_IDLE;
            awidx_q  <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            wstate_q <= wstate_d;
            if (aw_hs) awidx_q <= s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
            if (w_hs) begin
                wdata_q <= s_axi_wdata;
                wstrb_q <= s_axi_wstrb;
            end
        end
    end

    // Control registers, byte-lane update, single-cycle write pulse and response code.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            for (int unsigned k = 0; k < C_NUM_RW; k++) ctrl_q[k] <= '0;
            pulse_q <= '0;
            bresp_q <= RESP_OKAY;
        end else begin
            pulse_q <= '0;
            if (wr_commit) begin
                bresp_q <= wr_resp;
                for (int unsigned k = 0; k < C_NUM_RW; k++) begin
                    if (wr_idx == k) begin
                        pulse_q[k] <= 1'b1;
                        for (int unsigned b = 0; b < NB; b++) begin
                            if (wr_strb[b]) ctrl_q[k][b*8 +: 8] <= wr_data[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read mux over control registers and live status words.
    always_comb begin
        rd_word = '0;
        rd_resp = (rd_idx < NUM_MAP) ? RESP_OKAY : RESP_DECERR;
        for (int unsigned k = 0; k < C_NUM_RW; k++) begin
            if (rd_idx == k) rd_word = ctrl_q[k];
        end
        for (int unsigned k = 0; k < C_NUM_RO; k++) begin
            if (rd_idx == C_NUM_RW + k) rd_word = status_i[k*DW +: DW];
        end
    end

    // Read FSM next state.
    always_comb begin
        rstate_d = rstate_q;
        case (rstate_q)
            R_IDLE:  if (ar_hs) rstate_d = R_DATA;
            R_DATA:  if (s_axi_rready) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    // Read FSM state; data captured at the AR handshake and held until accepted.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rstate_q <= R_IDLE;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rstate_q <= rstate_d;
            if (ar_hs) begin
                rdata_q <= rd_word;
                rresp_q <= rd_resp;
            end
        end
    end

endmodule
